// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus decode-facing output.
// No storage or latency; wires only.
// Backpressure is carried by imemReqReady (memory side) and stall (decode side).
interface fetch_stage_if;
  // instruction memory request channel
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  // instruction memory response channel (in order, no backpressure)
  logic        imemRespValid;
  logic [31:0] imemRespData;
  // controller / decode side
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        outValid;
  logic [31:0] outPc;
  logic [31:0] outInstruction;

  // fetch stage drives requests and the decode-facing output
  modport master (
    output imemReqValid, imemReqAddr, outValid, outPc, outInstruction,
    input  imemReqReady, imemRespValid, imemRespData, stall, redirectValid, redirectPc
  );

  // memory model / controller / decode side
  modport slave (
    input  imemReqValid, imemReqAddr, outValid, outPc, outInstruction,
    output imemReqReady, imemRespValid, imemRespData, stall, redirectValid, redirectPc
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns fetch PC, issues in-order imem requests, buffers returned instructions.
// Latency: request accepted at t, response at t+k, instruction presented at t+k+1.
// Backpressure: stall holds the head entry; requests stop when allocated + stale-owed entries fill the queue.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fs_io
);

  // pointer and counter widths; counters must hold the value QUEUE_DEPTH itself
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = QUEUE_DEPTH[CW:0];

  // fetch PC
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  // queue storage: PC and instruction per entry, plus a filled flag
  logic [31:0]   pc_q    [QUEUE_DEPTH];
  logic [31:0]   pc_d    [QUEUE_DEPTH];
  logic [31:0]   instr_q [QUEUE_DEPTH];
  logic [31:0]   instr_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] filled_q, filled_d;

  // head = oldest entry, alloc = next free slot, fill = oldest entry still waiting for data
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q, fill_ptr_d;

  // alloc_cnt: entries in use; pend_cnt: allocated but unfilled;
  // drop_cnt: responses still owed for requests that a redirect has orphaned
  logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW:0]   occupancy;
  logic          req_vld;
  logic          accept;
  logic          out_vld;
  logic          pop;
  logic          resp_drop;
  logic          resp_fill;

  // Every owed response, live or stale, needs a slot reserved so memory never
  // returns more than the queue can absorb. Registered counts only, so a slot
  // freed by this cycle's pop is not reused until next cycle.
  assign occupancy = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
  assign req_vld   = !rst && !fs_io.redirectValid && (occupancy < DEPTH_W);
  assign accept    = req_vld && fs_io.imemReqReady;

  // Head is presentable once its data has landed; a redirect suppresses it.
  assign out_vld   = !rst && !fs_io.redirectValid && (alloc_cnt_q != '0) && filled_q[head_q];
  assign pop       = out_vld && !fs_io.stall;

  // Stale responses are consumed first because memory returns in request order.
  assign resp_drop = fs_io.imemRespValid && (drop_cnt_q != '0);
  assign resp_fill = fs_io.imemRespValid && (drop_cnt_q == '0) && (pend_cnt_q != '0);

  assign fs_io.imemReqValid   = req_vld;
  assign fs_io.imemReqAddr    = fetch_pc_q;
  assign fs_io.outValid       = out_vld;
  assign fs_io.outPc          = pc_q[head_q];
  assign fs_io.outInstruction = instr_q[head_q];

  // next-state: redirect flushes everything; otherwise allocate, fill and pop independently
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    filled_d    = filled_q;
    head_d      = head_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    alloc_cnt_d = alloc_cnt_q;
    pend_cnt_d  = pend_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (fs_io.redirectValid) begin
      // Unfilled entries become owed stale responses; a response arriving in
      // this very cycle settles one of them (either an already-stale one or
      // the oldest pending one).
      fetch_pc_d  = fs_io.redirectPc;
      filled_d    = '0;
      head_d      = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      alloc_cnt_d = '0;
      pend_cnt_d  = '0;
      drop_cnt_d  = drop_cnt_q + pend_cnt_q - CW'(fs_io.imemRespValid);
    end else begin
      if (accept) begin
        pc_d[alloc_ptr_q]     = fetch_pc_q;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + PW'(1);
        fetch_pc_d            = fetch_pc_q + 32'd4;
      end

      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end

      if (resp_fill) begin
        instr_d[fill_ptr_q]  = fs_io.imemRespData;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PW'(1);
      end

      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end

      alloc_cnt_d = alloc_cnt_q + CW'(accept) - CW'(pop);
      pend_cnt_d  = pend_cnt_q + CW'(accept) - CW'(resp_fill);
    end
  end

  // state registers; reset overrides redirect and clears the queue contents
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q    <= '0;
      head_q      <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      pend_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      filled_q    <= filled_d;
      head_q      <= head_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with configurable latency plus an output scoreboard.
// One step per clock; inputs driven at negedge, outputs sampled 1ns later.
// Backpressure exercised via stall, imemReqReady and redirect/reset flushes.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .fs_io (bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t  sb[$];
  mreq_t mq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat_k = 1;
  int last_due = 0;
  logic [31:0] exp_pc;

  logic        o_vld, o_req;
  logic [31:0] o_pc, o_ins, o_addr;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit resp_due();
    return (mq.size() > 0) && (mq[0].due <= cyc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs + memory response, sample, score, advance
  task automatic step(input logic rs, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic rdy);
    exp_t e;
    int   due;
    @(negedge clk);
    rst                = rs;
    bus.stall          = st;
    bus.redirectValid  = rd;
    bus.redirectPc     = rpc;
    bus.imemReqReady   = rdy;
    bus.imemRespValid  = 1'b0;
    bus.imemRespData   = '0;
    if (rs) begin
      mq.delete();
      last_due = cyc;
    end else if (resp_due()) begin
      bus.imemRespValid = 1'b1;
      bus.imemRespData  = ins_of(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    o_vld  = bus.outValid;
    o_req  = bus.imemReqValid;
    o_pc   = bus.outPc;
    o_ins  = bus.outInstruction;
    o_addr = bus.imemReqAddr;
    if (rs) begin
      chk("req_in_reset", 32'(o_req), 32'd0);
      sb.delete();
      exp_pc = RPC;
    end else if (rd) begin
      chk("out_in_redirect", 32'(o_vld), 32'd0);
      chk("req_in_redirect", 32'(o_req), 32'd0);
      sb.delete();
      exp_pc = rpc;
    end else begin
      if (o_vld && !st) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(o_vld), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_pc", o_pc, e.pc);
          chk("out_instr", o_ins, e.instr);
        end
      end
      if (o_req && rdy) begin
        chk("req_addr", o_addr, exp_pc);
        sb.push_back('{exp_pc, ins_of(exp_pc)});
        due = cyc + lat_k;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{o_addr, due});
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_zero;
    logic [31:0] hold_pc, hold_ins;

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirectValid = 1'b0;
    bus.redirectPc = '0;
    bus.imemReqReady = 1'b0;
    bus.imemRespValid = 1'b0;
    bus.imemRespData = '0;
    exp_pc = RPC;

    // reset state
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_out_vld", 32'(o_vld), 32'd0);
    chk("rst_out_pc", o_pc, 32'd0);
    chk("rst_out_instr", o_ins, 32'd0);

    // streaming with k=1, first output two cycles after first accept
    lat_k = 1;
    n = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 1);
      if (n < 0 && o_vld) begin
        n = i;
        chk("first_pc", o_pc, RPC);
      end
    end
    chk("first_out_lat", 32'(n), 32'd2);

    // stall four cycles: head held, queue fills, requests stop
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    hold_pc  = o_pc;
    hold_ins = o_ins;
    chk("stall_vld", 32'(o_vld), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 1);
      chk("stall_pc_hold", o_pc, hold_pc);
      chk("stall_ins_hold", o_ins, hold_ins);
      chk("stall_req_low", 32'(o_req), 32'd0);
    end

    // redirect while stalled with a full, fully-filled queue: no stale owed
    step(0, 1, 1, 32'h0000_3000, 1);
    n = -1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1);
      if (n < 0 && o_vld) begin
        n = i + 1;
        chk("redir_pc", o_pc, 32'h0000_3000);
      end
    end
    chk("redir_lat", 32'(n), 32'd3);

    // k=3, redirect with two requests outstanding: both responses dropped
    lat_k = 3;
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h0000_2000, 1);
    step(0, 0, 0, 0, 1);
    chk("drop_blocks_req", 32'(o_req), 32'd0);
    n = -1;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 0, 1);
      if (n < 0 && o_vld) begin
        n = i;
        chk("redir2_pc", o_pc, 32'h0000_2000);
      end
    end
    chk("redir2_lat", 32'(n), 32'd4);

    // k=2, redirect coinciding with a response while stalled
    lat_k = 2;
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (resp_due()) break;
      step(0, 1, 0, 0, 1);
    end
    chk("coincide_found", 32'(resp_due()), 32'd1);
    step(0, 1, 1, 32'h0000_4000, 1);
    n = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 1);
      if (n < 0 && o_vld) begin
        n = i + 1;
        chk("redir3_pc", o_pc, 32'h0000_4000);
      end
    end
    chk("redir3_lat", 32'(n), 32'd4);

    // ready low for 5 cycles: address held; then wrap past 0xFFFFFFFC
    lat_k = 1;
    step(0, 0, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("nordy_req_vld", 32'(o_req), 32'd1);
      chk("nordy_addr", o_addr, 32'hFFFF_FFF8);
    end
    saw_zero = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 1);
      if (o_req && o_addr == 32'd0) saw_zero = 1'b1;
    end
    chk("wrap_to_zero", 32'(saw_zero), 32'd1);

    // reset mid-stream with entries outstanding
    lat_k = 2;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("mid_rst_out_vld", 32'(o_vld), 32'd0);
    chk("mid_rst_req_vld", 32'(o_req), 32'd1);
    chk("mid_rst_addr", o_addr, RPC);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

    // drain everything still expected
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && mq.size() == 0) break;
      step(0, 0, 0, 0, 0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
